// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline front-end control slice: FSM encoding,
// register-zero constant and the MIPS opcode/funct values the ID decoder uses.
package pipe_ctrl_pkg;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MD_BUSY = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO   = 5'd0;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] FN_MFHI    = 6'h10;
   localparam logic [5:0] FN_MFLO    = 6'h12;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1a;
   localparam logic [5:0] FN_DIVU    = 6'h1b;

   // R-type funct codes that start the multiply/divide unit.
   function automatic logic is_md_start(input logic [5:0] opcode, input logic [5:0] funct);
      return (opcode == OP_SPECIAL) &&
             ((funct == FN_MULT) || (funct == FN_MULTU) ||
              (funct == FN_DIV)  || (funct == FN_DIVU));
   endfunction

   function automatic logic is_hilo_read(input logic [5:0] opcode, input logic [5:0] funct);
      return (opcode == OP_SPECIAL) && ((funct == FN_MFHI) || (funct == FN_MFLO));
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms: load-use against the ID instruction's sources,
// and the HI/LO interlock while the multiply/divide unit is busy.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic       IDEX_MemRead,
   input  logic [4:0] IDEX_Rt,
   input  logic [4:0] IFID_Rs,
   input  logic [4:0] IFID_Rt,
   input  logic       IFID_UsesRt,
   input  logic       IFID_MdStart,
   input  logic       IFID_ReadsHiLo,
   output logic       lu,
   output logic       md
);

   // $zero never carries a loaded value, so a load into it cannot create a hazard.
   assign lu = IDEX_MemRead && (IDEX_Rt != REG_ZERO) &&
               ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

   assign md = (state == ST_MD_BUSY) && (IFID_ReadsHiLo || IFID_MdStart);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end sequencing for the 5-stage pipeline: PC/IF-ID advance, hold or flush,
// ID/EX bubble injection, multiply/divide busy tracking and a stall counter.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_Rt,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             IFID_UsesRt,
   input  logic             IFID_MdStart,
   input  logic             IFID_ReadsHiLo,
   input  logic             PCsrc,
   output logic             PCWrite,
   output logic             enableIFIDReg,
   output logic             IFIDFlush,
   output logic             IDEXBubble,
   output logic             MdIssue,
   output logic             MdBusy,
   output logic [CNT_W-1:0] StallCycles
);

   localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

   state_t     state;
   logic [3:0] mdcnt;
   logic       lu;
   logic       md;

   hazard_detect u_hazard_detect (
      .state          (state),
      .IDEX_MemRead   (IDEX_MemRead),
      .IDEX_Rt        (IDEX_Rt),
      .IFID_Rs        (IFID_Rs),
      .IFID_Rt        (IFID_Rt),
      .IFID_UsesRt    (IFID_UsesRt),
      .IFID_MdStart   (IFID_MdStart),
      .IFID_ReadsHiLo (IFID_ReadsHiLo),
      .lu             (lu),
      .md             (md)
   );

   assign MdBusy = (state == ST_MD_BUSY);

   // Branch flush outranks stalls: the stalled ID instruction is on the wrong path.
   always_comb begin
      PCWrite       = 1'b1;
      enableIFIDReg = 1'b1;
      IFIDFlush     = 1'b0;
      IDEXBubble    = 1'b0;
      MdIssue       = 1'b0;
      if (Reset) begin
         PCWrite       = 1'b0;
         enableIFIDReg = 1'b0;
         IDEXBubble    = 1'b1;
      end else if (PCsrc) begin
         IFIDFlush  = 1'b1;
         IDEXBubble = 1'b1;
      end else if (lu || md) begin
         PCWrite       = 1'b0;
         enableIFIDReg = 1'b0;
         IDEXBubble    = 1'b1;
      end else if (IFID_MdStart && (state == ST_RUN)) begin
         MdIssue = 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= ST_RUN;
         mdcnt       <= 4'd0;
         StallCycles <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (MdIssue) begin
                  state <= ST_MD_BUSY;
                  mdcnt <= MD_LOAD;
               end
            end
            ST_MD_BUSY: begin
               // Counts down unconditionally; stalls and flushes do not pause the unit.
               if (mdcnt == 4'd1) begin
                  state <= ST_RUN;
                  mdcnt <= 4'd0;
               end else begin
                  mdcnt <= mdcnt - 4'd1;
               end
            end
            default: begin
               state <= ST_RUN;
               mdcnt <= 4'd0;
            end
         endcase
         if (!PCWrite && (StallCycles != {CNT_W{1'b1}}))
            StallCycles <= StallCycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl (MD_LAT=4, CNT_W=4); expected output
// vectors are queued at drive time and popped at the following falling edge.
module tb_pipe_hazard_ctrl;

   localparam int CNT_MAX = 15;
   // {PCWrite, enableIFIDReg, IFIDFlush, IDEXBubble, MdIssue, MdBusy}
   localparam logic [5:0] ADV  = 6'b110000;
   localparam logic [5:0] ADVB = 6'b110001;
   localparam logic [5:0] STL  = 6'b000100;
   localparam logic [5:0] STLB = 6'b000101;
   localparam logic [5:0] FLS  = 6'b111100;
   localparam logic [5:0] FLSB = 6'b111101;
   localparam logic [5:0] ISS  = 6'b110010;

   logic       Clk;
   logic       Reset;
   logic       IDEX_MemRead;
   logic [4:0] IDEX_Rt;
   logic [4:0] IFID_Rs;
   logic [4:0] IFID_Rt;
   logic       IFID_UsesRt;
   logic       IFID_MdStart;
   logic       IFID_ReadsHiLo;
   logic       PCsrc;
   logic       PCWrite;
   logic       enableIFIDReg;
   logic       IFIDFlush;
   logic       IDEXBubble;
   logic       MdIssue;
   logic       MdBusy;
   logic [3:0] StallCycles;
   logic [5:0] outv;

   logic [5:0] sb[$];
   int         checks = 0;
   int         errors = 0;
   int         exp_stalls = 0;
   int         stall_before = 0;
   logic [5:0] exp_v;
   logic [3:0] exp_cnt;

   pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .IDEX_MemRead   (IDEX_MemRead),
      .IDEX_Rt        (IDEX_Rt),
      .IFID_Rs        (IFID_Rs),
      .IFID_Rt        (IFID_Rt),
      .IFID_UsesRt    (IFID_UsesRt),
      .IFID_MdStart   (IFID_MdStart),
      .IFID_ReadsHiLo (IFID_ReadsHiLo),
      .PCsrc          (PCsrc),
      .PCWrite        (PCWrite),
      .enableIFIDReg  (enableIFIDReg),
      .IFIDFlush      (IFIDFlush),
      .IDEXBubble     (IDEXBubble),
      .MdIssue        (MdIssue),
      .MdBusy         (MdBusy),
      .StallCycles    (StallCycles)
   );

   assign outv = {PCWrite, enableIFIDReg, IFIDFlush, IDEXBubble, MdIssue, MdBusy};

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // One cycle of stimulus, entered 1 time unit after a rising edge.
   task automatic drive(input logic mr, input logic [4:0] ldrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ur, input logic ms,
                        input logic hl, input logic pc, input logic [5:0] exp);
      IDEX_MemRead   = mr;
      IDEX_Rt        = ldrt;
      IFID_Rs        = rs;
      IFID_Rt        = rt;
      IFID_UsesRt    = ur;
      IFID_MdStart   = ms;
      IFID_ReadsHiLo = hl;
      PCsrc          = pc;
      sb.push_back(exp);
      stall_before = exp_stalls;
      if (!exp[5]) exp_stalls++;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      drive(1, 5'd8, 5'd8, 0, 0, 1, 0, 1, STL);
      repeat (2) @(negedge Clk);
      exp_v = sb.pop_front();
      checks++;
      if (outv !== exp_v) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", outv, exp_v);
      end
      checks++;
      if (StallCycles !== 4'd0) begin
         errors++;
         $display("FAIL reset_counter: got %0d expected 0", StallCycles);
      end
      exp_stalls = 0;
      @(posedge Clk); #1;
      Reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, ADV);
      @(negedge Clk);
      exp_v = sb.pop_front();
      checks++;
      if (outv !== exp_v) begin
         errors++;
         $display("FAIL reset_release: got %b expected %b", outv, exp_v);
      end
      $display("test_reset done: out=%b cnt=%0d", outv, StallCycles);
   endtask

   task automatic test_load_use();
      for (int k = 0; k < 6; k++) begin
         @(posedge Clk); #1;
         case (k)
            0: drive(1, 5'd8, 5'd8, 5'd1, 0, 0, 0, 0, STL);
            1: drive(0, 0, 0, 0, 0, 0, 0, 0, ADV);
            2: drive(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, ADV);
            3: drive(1, 5'd9, 5'd3, 5'd9, 1, 0, 0, 0, STL);
            4: drive(1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0, ADV);
            default: drive(0, 0, 0, 0, 0, 0, 0, 0, ADV);
         endcase
         @(negedge Clk);
         exp_v = sb.pop_front();
         exp_cnt = 4'((stall_before > CNT_MAX) ? CNT_MAX : stall_before);
         checks += 2;
         if (outv !== exp_v) begin
            errors++;
            $display("FAIL load_use step %0d: got %b expected %b", k, outv, exp_v);
         end
         if (StallCycles !== exp_cnt) begin
            errors++;
            $display("FAIL load_use_cnt step %0d: got %0d expected %0d", k, StallCycles, exp_cnt);
         end
         $display("load_use step %0d: out=%b cnt=%0d", k, outv, StallCycles);
      end
   endtask

   task automatic test_mul();
      for (int k = 0; k < 6; k++) begin
         @(posedge Clk); #1;
         case (k)
            0:       drive(0, 0, 0, 0, 0, 1, 0, 0, ISS);
            1, 2, 3: drive(0, 0, 0, 0, 0, 0, 1, 0, STLB);
            4:       drive(0, 0, 0, 0, 0, 0, 1, 0, ADV);
            default: drive(0, 0, 0, 0, 0, 0, 0, 0, ADV);
         endcase
         @(negedge Clk);
         exp_v = sb.pop_front();
         exp_cnt = 4'((stall_before > CNT_MAX) ? CNT_MAX : stall_before);
         checks += 2;
         if (outv !== exp_v) begin
            errors++;
            $display("FAIL mul_interlock t+%0d: got %b expected %b", k, outv, exp_v);
         end
         if (StallCycles !== exp_cnt) begin
            errors++;
            $display("FAIL mul_cnt t+%0d: got %0d expected %0d", k, StallCycles, exp_cnt);
         end
         $display("mul t+%0d: out=%b cnt=%0d", k, outv, StallCycles);
      end
   endtask

   task automatic test_branch_over_stall();
      for (int k = 0; k < 2; k++) begin
         @(posedge Clk); #1;
         if (k == 0) drive(1, 5'd8, 5'd8, 0, 0, 0, 0, 1, FLS);
         else        drive(0, 0, 0, 0, 0, 0, 0, 0, ADV);
         @(negedge Clk);
         exp_v = sb.pop_front();
         exp_cnt = 4'((stall_before > CNT_MAX) ? CNT_MAX : stall_before);
         checks += 2;
         if (outv !== exp_v) begin
            errors++;
            $display("FAIL branch_over_stall step %0d: got %b expected %b", k, outv, exp_v);
         end
         if (StallCycles !== exp_cnt) begin
            errors++;
            $display("FAIL branch_cnt step %0d: got %0d expected %0d", k, StallCycles, exp_cnt);
         end
         $display("branch step %0d: out=%b cnt=%0d", k, outv, StallCycles);
      end
   endtask

   task automatic test_flush_md();
      for (int k = 0; k < 6; k++) begin
         @(posedge Clk); #1;
         case (k)
            0:       drive(0, 0, 0, 0, 0, 1, 0, 0, ISS);
            1:       drive(0, 0, 0, 0, 0, 0, 0, 0, ADVB);
            2:       drive(0, 0, 0, 0, 0, 1, 0, 1, FLSB);
            3:       drive(0, 0, 0, 0, 0, 1, 0, 0, STLB);
            4:       drive(0, 0, 0, 0, 0, 1, 0, 0, ISS);
            default: drive(0, 0, 0, 0, 0, 0, 0, 0, ADVB);
         endcase
         @(negedge Clk);
         exp_v = sb.pop_front();
         checks++;
         if (outv !== exp_v) begin
            errors++;
            $display("FAIL flush_md t+%0d: got %b expected %b", k, outv, exp_v);
         end
         $display("flush_md t+%0d: out=%b", k, outv);
      end
   endtask

   // Entered with a multiply in flight; reset lands between clock edges.
   task automatic test_async_reset();
      #1;
      Reset = 1'b1;
      #1;
      checks += 2;
      if (outv !== STL) begin
         errors++;
         $display("FAIL async_reset_outputs: got %b expected %b", outv, STL);
      end
      if (StallCycles !== 4'd0) begin
         errors++;
         $display("FAIL async_reset_cnt: got %0d expected 0", StallCycles);
      end
      exp_stalls = 0;
      @(posedge Clk); #1;
      Reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, ADV);
      @(negedge Clk);
      exp_v = sb.pop_front();
      checks += 2;
      if (outv !== exp_v) begin
         errors++;
         $display("FAIL async_reset_release: got %b expected %b", outv, exp_v);
      end
      if (StallCycles !== 4'd0) begin
         errors++;
         $display("FAIL async_reset_release_cnt: got %0d expected 0", StallCycles);
      end
      $display("async_reset: out=%b cnt=%0d", outv, StallCycles);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 9; k++) begin
         @(posedge Clk); #1;
         case (k)
            0:       drive(0, 0, 0, 0, 0, 1, 0, 0, ISS);
            1, 2, 3: drive(0, 0, 0, 0, 0, 1, 0, 0, STLB);
            4:       drive(0, 0, 0, 0, 0, 1, 0, 0, ISS);
            5, 6, 7: drive(0, 0, 0, 0, 0, 0, 0, 0, ADVB);
            default: drive(0, 0, 0, 0, 0, 0, 0, 0, ADV);
         endcase
         @(negedge Clk);
         exp_v = sb.pop_front();
         exp_cnt = 4'((stall_before > CNT_MAX) ? CNT_MAX : stall_before);
         checks += 2;
         if (outv !== exp_v) begin
            errors++;
            $display("FAIL back_to_back t+%0d: got %b expected %b", k, outv, exp_v);
         end
         if (StallCycles !== exp_cnt) begin
            errors++;
            $display("FAIL back_to_back_cnt t+%0d: got %0d expected %0d", k, StallCycles, exp_cnt);
         end
         $display("back_to_back t+%0d: out=%b cnt=%0d", k, outv, StallCycles);
      end
   endtask

   task automatic test_lu_mdstart();
      for (int k = 0; k < 6; k++) begin
         @(posedge Clk); #1;
         case (k)
            0:       drive(1, 5'd8, 5'd8, 0, 0, 1, 0, 0, STL);
            1:       drive(0, 0, 0, 0, 0, 1, 0, 0, ISS);
            2, 3, 4: drive(0, 0, 0, 0, 0, 0, 0, 0, ADVB);
            default: drive(0, 0, 0, 0, 0, 0, 0, 0, ADV);
         endcase
         @(negedge Clk);
         exp_v = sb.pop_front();
         checks++;
         if (outv !== exp_v) begin
            errors++;
            $display("FAIL lu_mdstart step %0d: got %b expected %b", k, outv, exp_v);
         end
         $display("lu_mdstart step %0d: out=%b", k, outv);
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 22; k++) begin
         @(posedge Clk); #1;
         if (k < 20) drive(1, 5'd4, 5'd4, 0, 0, 0, 0, 0, STL);
         else        drive(0, 0, 0, 0, 0, 0, 0, 0, ADV);
         @(negedge Clk);
         exp_v = sb.pop_front();
         exp_cnt = 4'((stall_before > CNT_MAX) ? CNT_MAX : stall_before);
         checks += 2;
         if (outv !== exp_v) begin
            errors++;
            $display("FAIL saturation step %0d: got %b expected %b", k, outv, exp_v);
         end
         if (StallCycles !== exp_cnt) begin
            errors++;
            $display("FAIL saturation_cnt step %0d: got %0d expected %0d", k, StallCycles, exp_cnt);
         end
         $display("saturation step %0d: out=%b cnt=%0d", k, outv, StallCycles);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_mul();
      test_branch_over_stall();
      test_flush_md();
      test_async_reset();
      test_back_to_back();
      test_lu_mdstart();
      test_saturation();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
